// File: rtl/can_bit_destuff_pkg.sv
// can_bit_destuff_pkg: shared CAN destuff state type, stuff run length and CRC-15 constants
package can_bit_destuff_pkg;
    typedef enum logic [1:0] {DS_IDLE, DS_RUN, DS_ERR} type_destuff_state_e;
    localparam int CAN_STUFF_RUN_LEN = 5;
    localparam int CAN_CRC15_W = 15;
    localparam logic [CAN_CRC15_W-1:0] CAN_CRC15_POLY = 15'h4599;
endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CAN CRC-15 (poly 0x4599, init 0) with enable and clear
module can_crc15 import can_bit_destuff_pkg::*; (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic                   bit_i,
    output logic [CAN_CRC15_W-1:0] crc_o
);
    logic [CAN_CRC15_W-1:0] crc_d, crc_q;
    always_comb begin
        crc_d = clr_i ? '0
              : en_i  ? ({crc_q[CAN_CRC15_W-2:0], 1'b0} ^ ((bit_i ^ crc_q[CAN_CRC15_W-1]) ? CAN_CRC15_POLY : '0))
              : crc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end
    assign crc_o = crc_q;
endmodule

// File: rtl/can_bit_destuff.sv
// can_bit_destuff: CAN receive bit destuffer; define CAN_DESTUFF_CRC_EN to add a running CRC-15 of destuffed bits
module can_bit_destuff import can_bit_destuff_pkg::*; #(
    parameter int RUN_LEN = CAN_STUFF_RUN_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_point_i,
    input  logic                   sampled_bit_i,
    input  logic                   destuff_en_i,
    input  logic                   clear_i,
    output logic                   bit_valid_o,
    output logic                   bit_o,
    output logic                   stuff_bit_o,
    output logic                   stuff_err_o,
    output logic                   stuff_err_flag_o,
    output logic [CAN_CRC15_W-1:0] crc_o,
    output logic                   crc_zero_o
);
    localparam logic [2:0] RL = 3'(RUN_LEN);
    type_destuff_state_e state_d, state_q;
    logic [2:0] run_cnt_d, run_cnt_q;
    logic last_bit_d, last_bit_q;
    logic bit_valid_d, bit_valid_q;
    logic bit_d, bit_q;
    logic stuff_bit_d, stuff_bit_q;
    logic stuff_err_d, stuff_err_q;
    logic err_flag_d, err_flag_q;
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        last_bit_d  = last_bit_q;
        bit_valid_d = 1'b0;
        bit_d       = bit_q;
        stuff_bit_d = 1'b0;
        stuff_err_d = 1'b0;
        err_flag_d  = err_flag_q;
        if (clear_i) begin
            state_d    = DS_IDLE;
            run_cnt_d  = '0;
            last_bit_d = 1'b1;
            err_flag_d = 1'b0;
        end else if (state_q != DS_ERR) begin
            if (!destuff_en_i) begin
                state_d     = DS_IDLE;
                run_cnt_d   = '0;
                last_bit_d  = 1'b1;
                bit_valid_d = sample_point_i;
                bit_d       = sample_point_i ? sampled_bit_i : bit_q;
            end else begin
                // idle keeps run_cnt=0/last_bit=1, so a rising enable evaluates from the reset run state
                state_d = DS_RUN;
                if (sample_point_i && run_cnt_q == RL) begin
                    if (sampled_bit_i != last_bit_q) begin
                        stuff_bit_d = 1'b1;
                        run_cnt_d   = 3'd1;
                        last_bit_d  = sampled_bit_i;
                    end else begin
                        stuff_err_d = 1'b1;
                        err_flag_d  = 1'b1;
                        state_d     = DS_ERR;
                    end
                end else if (sample_point_i) begin
                    bit_valid_d = 1'b1;
                    bit_d       = sampled_bit_i;
                    last_bit_d  = sampled_bit_i;
                    run_cnt_d   = (sampled_bit_i != last_bit_q) ? 3'd1 : run_cnt_q + 3'd1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DS_IDLE;
            run_cnt_q   <= '0;
            last_bit_q  <= 1'b1;
            bit_valid_q <= 1'b0;
            bit_q       <= 1'b1;
            stuff_bit_q <= 1'b0;
            stuff_err_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            last_bit_q  <= last_bit_d;
            bit_valid_q <= bit_valid_d;
            bit_q       <= bit_d;
            stuff_bit_q <= stuff_bit_d;
            stuff_err_q <= stuff_err_d;
            err_flag_q  <= err_flag_d;
        end
    end
    assign bit_valid_o      = bit_valid_q;
    assign bit_o            = bit_q;
    assign stuff_bit_o      = stuff_bit_q;
    assign stuff_err_o      = stuff_err_q;
    assign stuff_err_flag_o = err_flag_q;
`ifdef CAN_DESTUFF_CRC_EN
    can_crc15 u_crc (
        .clk   (clk),
        .rst   (rst),
        .en_i  (bit_valid_d & destuff_en_i),
        .clr_i (clear_i),
        .bit_i (sampled_bit_i),
        .crc_o (crc_o)
    );
`else
    assign crc_o = '0;
`endif
    assign crc_zero_o = (crc_o == '0);
endmodule
